// File: rtl/pc_fetch_unit_pkg.sv
// Shared next-PC select encodings and fixed vectors for pc_fetch_unit.
// Optional build macro IRQ_SYNC_EN adds a two-flop irq synchroniser.
package pc_fetch_unit_pkg;

    typedef enum logic [2:0] {
        PC_PLUS4  = 3'b000,
        PC_BRANCH = 3'b001,
        PC_JUMP   = 3'b010,
        PC_JR     = 3'b011,
        PC_IRQ    = 3'b100,
        PC_EXC    = 3'b101,
        PC_RSV6   = 3'b110,
        PC_RSV7   = 3'b111
    } pcsrc_e;

    localparam logic [31:0] RESET_VECTOR = 32'h8000_0000;
    localparam logic [31:0] IRQ_VECTOR   = 32'h8000_0004;
    localparam logic [31:0] EXC_VECTOR   = 32'h8000_0008;

    // Bit 31 is the supervisor flag; only the low 31 bits count.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return {pc[31], pc[30:0] + 31'd4};
    endfunction

endpackage

// File: rtl/pc_fetch_unit_irq_edge_sync.sv
// Interrupt request edge detector with pending flag (set beats clear).
// With IRQ_SYNC_EN defined, irq_raw first passes a two-flop synchroniser.
module irq_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_irq_raw,
    input  logic i_clear,
    output logic o_pending
);

    logic w_req;
    logic w_rise;
    logic r_prev;
    logic r_pending;

`ifdef IRQ_SYNC_EN
    logic r_s1;
    logic r_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_irq_raw;
            r_s2 <= r_s1;
        end
    end

    assign w_req = r_s2;
`else
    assign w_req = i_irq_raw;
`endif

    assign w_rise = w_req & ~r_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev    <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_prev <= w_req;
            if (w_rise)
                r_pending <= 1'b1;
            else if (i_clear)
                r_pending <= 1'b0;
        end
    end

    assign o_pending = r_pending;

endmodule

// File: rtl/pc_fetch_unit.sv
// IF stage: PC register, next-PC mux, interrupt request to IF/ID.
// Build option IRQ_SYNC_EN selects the synchronised irq path.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  PCSrc,
    input  logic        datahazard,
    input  logic [31:0] branch_target,
    input  logic [25:0] jump_target,
    input  logic [31:0] jr_target,
    input  logic        irq_raw,
    input  logic [31:0] instr_rdata,
    output logic [31:0] instr_addr,
    output logic [31:0] instruction_out,
    output logic [31:0] PCplus_out,
    output logic        IRQ_out
);

    logic [31:0] r_pc;
    logic [31:0] w_pc_plus;
    logic [31:0] w_jr;
    logic [31:0] w_next;
    logic        w_pending;
    logic        w_irq_take;

    assign w_pc_plus = pc_plus4(r_pc);

    // User mode cannot jump into kernel space via a register.
    assign w_jr = r_pc[31] ? jr_target : {1'b0, jr_target[30:0]};

    always_comb begin
        w_next = w_pc_plus;
        unique case (PCSrc)
            PC_PLUS4:  w_next = datahazard ? r_pc : w_pc_plus;
            PC_BRANCH: w_next = branch_target;
            PC_JUMP:   w_next = {r_pc[31:28], jump_target, 2'b00};
            PC_JR:     w_next = w_jr;
            PC_IRQ:    w_next = IRQ_VECTOR;
            PC_EXC:    w_next = EXC_VECTOR;
            default:   w_next = w_pc_plus;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_pc <= RESET_VECTOR;
        else
            r_pc <= w_next;
    end

    assign w_irq_take = (PCSrc == PC_IRQ);

    irq_edge_sync u_irq (
        .clk       (clk),
        .reset     (reset),
        .i_irq_raw (irq_raw),
        .i_clear   (w_irq_take),
        .o_pending (w_pending)
    );

    assign instr_addr      = r_pc;
    assign instruction_out = instr_rdata;
    assign PCplus_out      = w_pc_plus;
    assign IRQ_out         = w_pending & ~r_pc[31];

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with an in-bench reference model.
// Build with or without IRQ_SYNC_EN; the model follows the same macro.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  PCSrc;
    logic        datahazard;
    logic [31:0] branch_target;
    logic [25:0] jump_target;
    logic [31:0] jr_target;
    logic        irq_raw;
    logic [31:0] instr_rdata;
    logic [31:0] instr_addr;
    logic [31:0] instruction_out;
    logic [31:0] PCplus_out;
    logic        IRQ_out;

`ifdef IRQ_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] m_pc;
    bit          m_pend;
    bit          hist[$];
    bit          chk_en = 1'b0;

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .PCSrc           (PCSrc),
        .datahazard      (datahazard),
        .branch_target   (branch_target),
        .jump_target     (jump_target),
        .jr_target       (jr_target),
        .irq_raw         (irq_raw),
        .instr_rdata     (instr_rdata),
        .instr_addr      (instr_addr),
        .instruction_out (instruction_out),
        .PCplus_out      (PCplus_out),
        .IRQ_out         (IRQ_out)
    );

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Apply the model's rules at one rising edge using the driven inputs.
    task automatic model_edge();
        logic [31:0] plus;
        int          sz;
        bit          rise;
        if (reset) begin
            m_pc   = 32'h8000_0000;
            m_pend = 1'b0;
            hist   = {1'b0, 1'b0, 1'b0, 1'b0};
            return;
        end
        hist.push_back(irq_raw);
        sz   = hist.size();
        rise = hist[sz-1-LAT] && !hist[sz-2-LAT];
        if (rise)
            m_pend = 1'b1;
        else if (PCSrc == 3'd4)
            m_pend = 1'b0;
        plus = {m_pc[31], m_pc[30:0] + 31'd4};
        case (PCSrc)
            3'd0: m_pc = datahazard ? m_pc : plus;
            3'd1: m_pc = branch_target;
            3'd2: m_pc = {m_pc[31:28], jump_target, 2'b00};
            3'd3: m_pc = m_pc[31] ? jr_target
                                  : (jr_target & 32'h7FFF_FFFF);
            3'd4: m_pc = 32'h8000_0004;
            3'd5: m_pc = 32'h8000_0008;
            default: m_pc = plus;
        endcase
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("addr", instr_addr, m_pc);
            check("plus", PCplus_out,
                  {m_pc[31], m_pc[30:0] + 31'd4});
            check("instr", instruction_out, instr_rdata);
            check("irq", {31'd0, IRQ_out},
                  {31'd0, m_pend & ~m_pc[31]});
        end
    end

    task automatic step(input logic [2:0] src, input logic hz,
                        input logic irq);
        PCSrc       = src;
        datahazard  = hz;
        irq_raw     = irq;
        instr_rdata = $urandom;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        #1;
    endtask

    task automatic go_branch(input logic [31:0] tgt, input logic irq);
        branch_target = tgt;
        step(3'd1, 1'b0, irq);
    endtask

    initial begin
        reset         = 1'b1;
        PCSrc         = 3'd1;
        datahazard    = 1'b1;
        branch_target = 32'h1234_5678;
        jump_target   = '0;
        jr_target     = '0;
        irq_raw       = 1'b1;
        instr_rdata   = '0;
        m_pc          = '0;
        m_pend        = 1'b0;
        @(negedge clk);
        step(3'd1, 1'b1, 1'b1);
        step(3'd1, 1'b1, 1'b1);
        chk_en = 1'b1;
        check("rst_pc", instr_addr, 32'h8000_0000);
        check("rst_plus", PCplus_out, 32'h8000_0004);
        check("rst_irq", {31'd0, IRQ_out}, 32'd0);
        reset = 1'b0;

        step(3'd0, 1'b0, 1'b0);
        check("seq1", instr_addr, 32'h8000_0004);
        step(3'd0, 1'b0, 1'b0);
        check("seq2", instr_addr, 32'h8000_0008);
        check("seq2_plus", PCplus_out, 32'h8000_000C);

        jr_target = 32'h0040_0010;
        step(3'd3, 1'b0, 1'b0);
        check("jr_kern", instr_addr, 32'h0040_0010);
        step(3'd0, 1'b1, 1'b0);
        step(3'd0, 1'b1, 1'b0);
        check("stall", instr_addr, 32'h0040_0010);
        branch_target = 32'h0040_0100;
        step(3'd1, 1'b1, 1'b0);
        check("br_ovr", instr_addr, 32'h0040_0100);

        go_branch(32'h0040_0000, 1'b0);
        jump_target = 26'h010_0040;
        step(3'd2, 1'b0, 1'b0);
        check("jump", instr_addr, 32'h0040_0100);
        jr_target = 32'h8000_1234;
        step(3'd3, 1'b0, 1'b0);
        check("jr_user", instr_addr, 32'h0000_1234);

        go_branch(32'h0040_0000, 1'b0);
        step(3'd0, 1'b0, 1'b1);
        check("irq_lat1", {31'd0, IRQ_out}, (LAT == 0) ? 32'd1 : 32'd0);
        step(3'd0, 1'b1, 1'b1);
        step(3'd0, 1'b1, 1'b1);
        check("irq_lat3", {31'd0, IRQ_out}, 32'd1);
        step(3'd4, 1'b0, 1'b1);
        check("irq_vec", instr_addr, 32'h8000_0004);
        check("irq_clr", {31'd0, IRQ_out}, 32'd0);

        go_branch(32'h0040_0000, 1'b0);
        for (int i = 0; i < 3; i++) step(3'd0, 1'b0, 1'b0);
        for (int i = 0; i < LAT; i++) step(3'd0, 1'b0, 1'b1);
        step(3'd4, 1'b0, 1'b1);
        check("edge_vs_clr", {31'd0, m_pend}, 32'd1);
        step(3'd5, 1'b0, 1'b1);
        check("exc_vec", instr_addr, 32'h8000_0008);

        go_branch(32'h8000_0100, 1'b0);
        for (int i = 0; i < 3; i++) step(3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(3'd0, 1'b0, 1'b1);
        check("irq_mask", {31'd0, IRQ_out}, 32'd0);
        jr_target = 32'h0040_0000;
        step(3'd3, 1'b0, 1'b1);
        check("irq_unmask", {31'd0, IRQ_out}, 32'd1);
        step(3'd4, 1'b0, 1'b0);

        go_branch(32'h7FFF_FFFC, 1'b0);
        step(3'd0, 1'b0, 1'b0);
        check("wrap_user", instr_addr, 32'h0000_0000);
        go_branch(32'hFFFF_FFFC, 1'b0);
        step(3'd0, 1'b0, 1'b0);
        check("wrap_kern", instr_addr, 32'h8000_0000);
        step(3'd6, 1'b1, 1'b0);
        check("rsv6", instr_addr, 32'h8000_0004);
        step(3'd7, 1'b1, 1'b0);
        check("rsv7", instr_addr, 32'h8000_0008);

        chk_en = 1'b0;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high.
REQ-003 SHALL have: PCSrc  in  3  next-PC select from ID/EX control.
REQ-004 SHALL have: datahazard  in  1  load-use stall; holds PC.
REQ-005 SHALL have: branch_target  in  32  taken-branch address.
REQ-006 SHALL have: jump_target  in  26  J/JAL instruction index field.
REQ-007 SHALL have: jr_target  in  32  JR/JALR register value.
REQ-008 SHALL have: irq_raw  in  1  level interrupt request from peripherals.
REQ-009 SHALL have: instr_rdata  in  32  instruction memory read data, combinational.
REQ-010 SHALL have: instr_addr  out  32  instruction memory address, equal to PC.
REQ-011 SHALL have: instruction_out  out  32  fetched word to IF/ID.
REQ-012 SHALL have: PCplus_out  out  32  PC+4 with supervisor bit preserved, to IF/ID.
REQ-013 SHALL have: IRQ_out  out  1  interrupt request to IF/ID.

Function
REQ-014 PC register SHALL update once per clk; instr_addr = PC; instruction_out = instr_rdata (zero added latency).
REQ-015 PCplus_out SHALL be {PC[31], PC[30:0]+4}; bits 30:0 wrap modulo 2^31, bit 31 never changes through increment.
REQ-016 Next PC SHALL be: 000 -> PCplus_out, or PC unchanged when datahazard=1; 001 -> branch_target; 010 -> {PC[31:28], jump_target, 2'b00}; 011 -> jr_target; 100 -> 0x80000004 (interrupt vector); 101 -> 0x80000008 (exception vector); 110/111 -> PCplus_out.
REQ-017 Any PCSrc != 000 SHALL override datahazard (redirect wins over stall).
REQ-018 User-mode jr_target with bit 31 = 1 SHALL load with bit 31 forced to 0; kernel mode (PC[31]=1) SHALL load jr_target unmodified.
REQ-019 Interrupt pending flag SHALL set on a rising edge of the synchronised request (0->1 between consecutive samples).
REQ-020 Pending SHALL clear on the cycle PCSrc = 100 is applied; a new edge in that same cycle SHALL leave pending set.
REQ-021 IRQ_out SHALL equal pending AND NOT PC[31] (masked in kernel mode); pending SHALL persist while masked.
REQ-022 During datahazard with PCSrc = 000, pending SHALL still capture edges; IRQ_out SHALL track pending combinationally.

Reset
REQ-023 On reset=1 at clk edge: PC <= 0x80000000, pending <= 0, synchroniser and edge-detect flops <= 0.
REQ-024 Reset SHALL dominate PCSrc, datahazard and irq_raw in the same cycle; after reset, IRQ_out = 0 and PCplus_out = 0x80000004.

Configuration
REQ-025 Macro IRQ_SYNC_EN defined: irq_raw SHALL pass a two-flop synchroniser before edge detection (2 extra cycles of latency).
REQ-026 Macro IRQ_SYNC_EN undefined: irq_raw SHALL feed edge detection directly (single sample flop only).

Structure
REQ-027 Shared package SHALL hold PCSrc encodings (PC_PLUS4, PC_BRANCH, PC_JUMP, PC_JR, PC_IRQ, PC_EXC), RESET_VECTOR, IRQ_VECTOR and EXC_VECTOR constants.
REQ-028 One sub-module SHALL exist: irq_edge_sync (optional synchroniser, edge detect, pending flag with set-priority clear).

Verification
REQ-029 Reset, then 3 cycles PCSrc=000 -> instr_addr 0x80000000, 0x80000004, 0x80000008; PCplus_out 0x8000000C.
REQ-030 PC=0x00400010, datahazard=1 for 2 cycles -> PC holds 0x00400010; then PCSrc=001 with datahazard=1, branch_target=0x00400100 -> PC 0x00400100.
REQ-031 PC=0x00400000, PCSrc=010, jump_target=0x0100040 -> PC 0x00400100; PCSrc=011, jr_target=0x80001234 in user mode -> PC 0x00001234.
REQ-032 PC=0x00400000, irq_raw 0->1 -> IRQ_out=1 after 1 cycle (3 with IRQ_SYNC_EN); PCSrc=100 -> PC 0x80000004, IRQ_out=0.
REQ-033 PC=0x80000100, irq edge -> IRQ_out=0, pending=1; jr_target=0x00400000 with PCSrc=011 -> IRQ_out=1 next cycle.
REQ-034 PC=0x7FFFFFFC, PCSrc=000 -> PC 0x00000000; PC=0xFFFFFFFC -> PC 0x80000000.
